// File: rtl/hash_enc_pkg.sv
// Shared types and constants for the hash_encoding pipeline (index calculator and feature fetch).
package hash_enc_pkg;

    localparam int unsigned N_CORNERS      = 8;
    localparam int unsigned FEAT_WIDTH_DEF = 16;
    localparam int unsigned FEAT_DIM_DEF   = 2;
    localparam int unsigned ENTRY_W_DEF    = FEAT_WIDTH_DEF * FEAT_DIM_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } fetch_state_t;

    typedef logic [ENTRY_W_DEF-1:0] feat_entry_t;

endpackage

// File: rtl/hash_feat_fetch.sv
// Fetches the 8 corner feature entries of one hash-index group from the level table.
// Optional sticky err output for unexpected read responses: define HASH_FEAT_FETCH_ERR_EN.
module hash_feat_fetch
    import hash_enc_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned TABLE_SIZE = 4096,
    parameter int unsigned FEAT_WIDTH = FEAT_WIDTH_DEF,
    parameter int unsigned FEAT_DIM   = FEAT_DIM_DEF,
    localparam int unsigned ENTRY_W   = FEAT_WIDTH * FEAT_DIM,
    localparam int unsigned ADDR_W    = $clog2(TABLE_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idx_valid,
    output logic                 idx_ready,
    input  logic [DATA_SIZE-1:0] hash_idx [N_CORNERS],
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [ENTRY_W-1:0]   mem_rdata,
    output logic                 feat_valid,
    input  logic                 feat_ready,
    output logic [ENTRY_W-1:0]   feat [N_CORNERS],
    output logic                 busy
`ifdef HASH_FEAT_FETCH_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int unsigned IDX_W = $clog2(N_CORNERS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CORNERS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CORNERS);

    if (TABLE_SIZE < 2 || (TABLE_SIZE & (TABLE_SIZE - 1)) != 0) begin : g_bad_table_size
        $error("hash_feat_fetch: TABLE_SIZE must be a power of two");
    end

    fetch_state_t     state, state_d;
    logic [CNT_W-1:0] iss_cnt, iss_cnt_d;
    logic [CNT_W-1:0] rcv_cnt, rcv_cnt_d;
    logic [ADDR_W-1:0] addr [N_CORNERS];
    logic [ADDR_W-1:0] next_addr;
    logic             capture;
    logic             rsp_take;
    logic             idx_hi_unused;

    // Index bits above the table size are discarded (address = index mod TABLE_SIZE).
    always_comb begin : idx_fold
        idx_hi_unused = 1'b0;
        for (int i = 0; i < int'(N_CORNERS); i++) begin
            idx_hi_unused = idx_hi_unused ^ (^hash_idx[i]);
        end
    end

    always_comb begin : next_state
        state_d   = state;
        iss_cnt_d = iss_cnt;
        rcv_cnt_d = rcv_cnt;
        capture   = 1'b0;
        rsp_take  = 1'b0;

        case (state)
            IDLE: begin
                if (idx_valid) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    iss_cnt_d = iss_cnt + CNT_W'(1);
                end
            end
            OUT: begin
                if (feat_ready) begin
                    state_d   = IDLE;
                    iss_cnt_d = '0;
                    rcv_cnt_d = '0;
                end
            end
            default: ;
        endcase

        // A response is only owed for requests already granted, including one granted this cycle.
        if ((state == ISSUE || state == WAIT) && mem_rvalid && (rcv_cnt < iss_cnt_d)) begin
            rsp_take  = 1'b1;
            rcv_cnt_d = rcv_cnt + CNT_W'(1);
        end

        if (state == ISSUE && mem_gnt && iss_cnt == CNT_LAST) begin
            state_d = (rcv_cnt_d == CNT_FULL) ? OUT : WAIT;
        end
        if (state == WAIT && rcv_cnt_d == CNT_FULL) begin
            state_d = OUT;
        end

        next_addr = capture ? hash_idx[0][ADDR_W-1:0] : addr[iss_cnt_d[IDX_W-1:0]];
    end

    // State, counters and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state      <= IDLE;
            iss_cnt    <= '0;
            rcv_cnt    <= '0;
            idx_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            feat_valid <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < int'(N_CORNERS); i++) begin
                addr[i] <= '0;
                feat[i] <= '0;
            end
        end else begin
            state      <= state_d;
            iss_cnt    <= iss_cnt_d;
            rcv_cnt    <= rcv_cnt_d;
            idx_ready  <= (state_d == IDLE);
            mem_req    <= (state_d == ISSUE);
            feat_valid <= (state_d == OUT);
            busy       <= (state_d != IDLE);
            if (state_d == ISSUE) begin
                mem_addr <= next_addr;
            end
            if (capture) begin
                for (int i = 0; i < int'(N_CORNERS); i++) begin
                    addr[i] <= hash_idx[i][ADDR_W-1:0];
                end
            end
            if (rsp_take) begin
                feat[rcv_cnt[IDX_W-1:0]] <= mem_rdata;
            end
        end
    end

`ifdef HASH_FEAT_FETCH_ERR_EN
    // Sticky flag for any response that was not owed.
    always_ff @(posedge clk) begin : err_reg
        if (rst) begin
            err <= 1'b0;
        end else if (mem_rvalid && !rsp_take) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hash_feat_fetch.sv
// Directed bench for hash_feat_fetch with a randomisable in-order memory model and scoreboard.
module tb_hash_feat_fetch;

    localparam int unsigned AW = 12;
    localparam int unsigned EW = 32;

    typedef struct {
        int unsigned      due;
        logic [EW-1:0]    data;
    } rsp_t;

    logic          clk;
    logic          rst;
    logic          idx_valid;
    logic          idx_ready;
    logic [31:0]   hash_idx [8];
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [EW-1:0] mem_rdata;
    logic          feat_valid;
    logic          feat_ready;
    logic [EW-1:0] feat [8];
    logic          busy;
`ifdef HASH_FEAT_FETCH_ERR_EN
    logic          err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [EW-1:0] exp_feat_q [$];
    rsp_t          rsp_q [$];

    int unsigned cyc     = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit          mem_en  = 1'b1;
    int          inj_cnt = 0;
    int          beats   = 0;
    int          req_cnt = 0;

    hash_feat_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .hash_idx   (hash_idx),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat       (feat),
        .busy       (busy)
`ifdef HASH_FEAT_FETCH_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] mdata(input logic [AW-1:0] a);
        return {a, 4'h3, ~a, 4'hC};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: grants, in-order responses, request checks against the scoreboard.
    initial begin : mem_model
        logic          prev_req;
        logic          prev_gnt;
        logic          prev_rst;
        logic [AW-1:0] prev_addr;
        logic          g;
        int unsigned   due;
        rsp_t          r;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
        prev_rst   = 1'b1;
        prev_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (prev_req && !prev_gnt && !prev_rst) begin
                chk("req_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
            end
            g = 1'b0;
            if (mem_en && mem_req) begin
                g = ($urandom_range(99, 0) < gnt_pct);
            end
            mem_gnt = g;
            if (g) begin
                req_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("extra_req", 64'(mem_req), 64'd0);
                end else begin
                    chk("req_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                end
                due = cyc + $urandom_range(lat_max, lat_min);
                if (rsp_q.size() > 0 && due <= rsp_q[$].due) begin
                    due = rsp_q[$].due + 1;
                end
                rsp_q.push_back('{due, mdata(mem_addr)});
            end
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (inj_cnt > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_0000 | 32'(inj_cnt);
                inj_cnt--;
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r          = rsp_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = r.data;
                beats++;
            end
            prev_req  = mem_req;
            prev_gnt  = g;
            prev_rst  = rst;
            prev_addr = mem_addr;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] g [8]);
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(g[i][AW-1:0]);
            exp_feat_q.push_back(mdata(g[i][AW-1:0]));
        end
    endtask

    task automatic start_group(input logic [31:0] g [8]);
        hash_idx  = g;
        idx_valid = 1'b1;
        push_exp(g);
        step();
        idx_valid = 1'b0;
    endtask

    // n is the cycle index (handshake cycle = 0) at which feat_valid is first seen.
    task automatic wait_feat(input string tag, output int n, output int rdy_seen);
        n        = 1;
        rdy_seen = 0;
        while (!feat_valid && n < 300) begin
            if (idx_ready) rdy_seen++;
            step();
            n++;
        end
        if (n >= 300) chk({tag, "_timeout"}, 64'(feat_valid), 64'd1);
    endtask

    task automatic check_bundle(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (exp_feat_q.size() > 0) begin
                chk($sformatf("%s_feat%0d", tag, i), 64'(feat[i]), 64'(exp_feat_q.pop_front()));
            end
        end
    endtask

    task automatic consume(input string tag);
        feat_ready = 1'b1;
        step();
        feat_ready = 1'b0;
        chk({tag, "_idle_ready"}, 64'({idx_ready, feat_valid, busy}), 64'(3'b100));
    endtask

    initial begin : main
        logic [31:0] g [8];
        int n;
        int rdy;
        rst        = 1'b1;
        idx_valid  = 1'b0;
        feat_ready = 1'b0;
        for (int i = 0; i < 8; i++) hash_idx[i] = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset values
        chk("rst_ctrl", 64'({idx_ready, mem_req, feat_valid, busy}), 64'(4'b1000));
        chk("rst_addr", 64'(mem_addr), 64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_feat%0d", i), 64'(feat[i]), 64'd0);
        chk("rst_iss", 64'(dut.iss_cnt), 64'd0);
        chk("rst_rcv", 64'(dut.rcv_cnt), 64'd0);

        // Fixed group, gnt always, 1-cycle memory
        g = '{32'h0, 32'h1, 32'h1001, 32'h2FFF, 32'h1234_5678, 32'h7, 32'h8, 32'hFFFF_FFFF};
        start_group(g);
        chk("t1_first_req", 64'({mem_req, mem_addr, busy, idx_ready}), 64'({1'b1, 12'h000, 1'b1, 1'b0}));
        wait_feat("t1", n, rdy);
        chk("t1_latency", 64'(n), 64'd10);
        chk("t1_rdy_busy", 64'(rdy), 64'd0);
        check_bundle("t1");
        consume("t1");

        // Random grants and response latency 1..4
        gnt_pct = 50; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) g[i] = $urandom;
            req_cnt = 0;
            start_group(g);
            wait_feat("t2", n, rdy);
            chk($sformatf("t2_reqs%0d", k), 64'(req_cnt), 64'd8);
            check_bundle($sformatf("t2_%0d", k));
            repeat (3) step();
            chk($sformatf("t2_no_extra%0d", k), 64'({mem_req, feat_valid}), 64'(2'b01));
            consume("t2");
        end

        // Downstream stall in OUT with a new group already offered
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) g[i] = $urandom;
        start_group(g);
        wait_feat("t3", n, rdy);
        for (int i = 0; i < 8; i++) g[i] = 32'hA000_0000 + 32'(i * 517);
        hash_idx  = g;
        idx_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("t3_hold%0d", c), 64'({feat_valid, idx_ready, mem_req}), 64'(3'b100));
        end
        check_bundle("t3");

        // Back-to-back: second group accepted the cycle after the feat handshake
        push_exp(g);
        feat_ready = 1'b1;
        step();
        feat_ready = 1'b0;
        chk("t4_idle", 64'({idx_ready, feat_valid, busy}), 64'(3'b100));
        step();
        chk("t4_accept", 64'({idx_ready, busy, mem_req, mem_addr}), 64'({1'b0, 1'b1, 1'b1, g[0][AW-1:0]}));
        idx_valid = 1'b0;
        wait_feat("t4", n, rdy);
        chk("t4_rdy_busy", 64'(rdy), 64'd0);
        check_bundle("t4");
        consume("t4");

        // Reset in WAIT after 3 responses, then stale responses
        lat_min = 8; lat_max = 8;
        for (int i = 0; i < 8; i++) g[i] = $urandom;
        beats = 0;
        start_group(g);
        n = 0;
        while (beats < 3 && n < 100) begin
            step();
            n++;
        end
        chk("t5_in_wait", 64'({busy, mem_req, feat_valid, beats}), 64'({1'b1, 1'b0, 1'b0, 32'd3}));
        mem_en = 1'b0;
        rsp_q.delete();
        exp_feat_q.delete();
        exp_addr_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_ctrl", 64'({idx_ready, mem_req, feat_valid, busy}), 64'(4'b1000));
`ifdef HASH_FEAT_FETCH_ERR_EN
        chk("t5_err_clr", 64'(err), 64'd0);
`endif
        inj_cnt = 5;
        repeat (7) step();
        chk("t5_post_ctrl", 64'({idx_ready, mem_req, feat_valid, busy}), 64'(4'b1000));
        chk("t5_post_addr", 64'(mem_addr), 64'd0);
        chk("t5_post_cnt", 64'({dut.iss_cnt, dut.rcv_cnt}), 64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_feat%0d", i), 64'(feat[i]), 64'd0);
`ifdef HASH_FEAT_FETCH_ERR_EN
        chk("t5_err_set", 64'(err), 64'd1);
`endif
        mem_en = 1'b1;

        // Zero-latency memory: response lands with each grant, including the 8th
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 8; i++) g[i] = $urandom;
        start_group(g);
        wait_feat("t6", n, rdy);
        chk("t6_latency", 64'(n), 64'd9);
        chk("t6_cnt", 64'({dut.iss_cnt, dut.rcv_cnt}), 64'({4'd8, 4'd8}));
        check_bundle("t6");
        consume("t6");

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
